// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings used by the
// decoder and hazard unit, the controller state type and the counter width.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'b0000,
    OP_MULT  = 4'b0001,
    OP_MULTU = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_DIVU  = 4'b0100,
    OP_MTHI  = 4'b0101,
    OP_MTLO  = 4'b0110,
    OP_MFHI  = 4'b0111,
    OP_MFLO  = 4'b1000
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Wide enough for any sensible latency parameter.
  localparam int CNT_W = 16;

  // MULT and DIV use two's-complement operands; the U variants do not.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage operand/result bundle between the pipeline and the MD unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        start;
  logic        cancel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  modport master (
    output A, B, MDOp, start, cancel,
    input  busy, HI, LO, MDOut
  );

  modport slave (
    input  A, B, MDOp, start, cancel,
    output busy, HI, LO, MDOut
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product, quotient and remainder, with a
// signed/unsigned select. Results are sampled by mdu only at an accepted start.
module mdu_calc (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Sign-extending to 64 bits makes the low 64 bits of the product correct
  // for both signed and unsigned operands.
  assign a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  // Divide; the most-negative / -1 overflow case wraps to the dividend with a
  // zero remainder, and a zero divisor yields zeros (the result is discarded).
  always_comb begin
    quot = 32'd0;
    rem  = 32'd0;
    if (b != 32'd0) begin
      if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
        quot = 32'h8000_0000;
        rem  = 32'd0;
      end else if (sgn) begin
        quot = $signed(a) / $signed(b);
        rem  = $signed(a) % $signed(b);
      end else begin
        quot = a / b;
        rem  = a % b;
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV sequencing with shadow result
// registers, architectural HI/LO, and MTHI/MTLO/MFHI/MFLO service.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation in flight, busy=0, starts may be accepted
// ST_RUN  | counter counting down; HI/LO committed when it reaches 1
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_t;
  logic [31:0]      lo_t;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             div_zero;
  logic             accept;
  logic [63:0]      prod;
  logic [31:0]      quot;
  logic [31:0]      rem;

  mdu_calc u_calc (
    .a    (bus.A),
    .b    (bus.B),
    .sgn  (is_signed_op(bus.MDOp)),
    .prod (prod),
    .quot (quot),
    .rem  (rem)
  );

  // A start during RUN is a stall violation upstream and is simply dropped.
  assign accept = bus.start && !bus.cancel && (state == ST_IDLE);

  // Controller: latch operands' results at accept, count down, commit at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_t     <= 32'd0;
      lo_t     <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.MDOp)
              OP_MULT, OP_MULTU: begin
                hi_t     <= prod[63:32];
                lo_t     <= prod[31:0];
                div_zero <= 1'b0;
                cnt      <= CNT_W'(MULT_CYCLES);
                state    <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                hi_t     <= rem;
                lo_t     <= quot;
                div_zero <= (bus.B == 32'd0);
                cnt      <= CNT_W'(DIV_CYCLES);
                state    <= ST_RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            // A zero divisor still runs the full latency but leaves HI/LO alone.
            if (!div_zero) begin
              hi_q <= hi_t;
              lo_q <= lo_t;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Move-from result; stale while busy, which the ID stall hides.
  always_comb begin
    bus.MDOut = 32'd0;
    if (bus.MDOp == OP_MFHI) bus.MDOut = hi_q;
    else if (bus.MDOp == OP_MFLO) bus.MDOut = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: scoreboard of expected HI/LO/latency pushed at issue and
// compared when busy drops.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } row_t;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   viol_cnt = 0;
  exp_t sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall-violation monitor: a start while busy must never reach the unit.
  always @(posedge clk)
    if (reset && bus.start && bus.busy) viol_cnt <= viol_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model built from magnitudes and sign fix-up.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    e.hi = m_hi; e.lo = m_lo; e.lat = 0;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = b[31] ? (~b + 32'd1) : b;
    case (op)
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MC;
      end
      OP_MULT: begin
        p = {32'd0, ma} * {32'd0, mb};
        if (a[31] ^ b[31]) p = ~p + 64'd1;
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MC;
      end
      OP_DIVU: begin
        e.lat = DC;
        if (b != 32'd0) begin e.lo = a / b; e.hi = a % b; end
      end
      OP_DIV: begin
        e.lat = DC;
        if (b != 32'd0) begin
          q = ma / mb; r = ma % mb;
          if (a[31] ^ b[31]) q = ~q + 32'd1;
          if (a[31]) r = ~r + 32'd1;
          e.lo = q; e.hi = r;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one MULT/DIV-class op at the current negedge and wait for busy to
  // drop. mode 1: pulse cancel mid-run; mode 2: change operands and inject a start.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int mode, output int nbusy);
    sb.push_back(e);
    bus.A = a; bus.B = b; bus.MDOp = op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.MDOp = OP_NONE;
    nbusy = 0;
    while (bus.busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      if (mode == 1 && nbusy == 1) bus.cancel = 1'b1;
      if (mode == 1 && nbusy == 3) bus.cancel = 1'b0;
      if (mode == 2 && nbusy == 2) begin
        bus.A = ~a; bus.B = b + 32'd5; bus.MDOp = OP_DIV; bus.start = 1'b1;
      end
      if (mode == 2 && nbusy == 3) begin bus.start = 1'b0; bus.MDOp = OP_NONE; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.A = '0; bus.B = '0; bus.MDOp = OP_NONE; bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.LO); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    row_t rows[4] = '{
      '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA},
      '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA},
      '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001}
    };
    exp_t e;
    int   nb;
    foreach (rows[i]) begin
      e.hi = rows[i].hi; e.lo = rows[i].lo; e.lat = MC;
      run_op(rows[i].op, rows[i].a, rows[i].b, e, 0, nb);
      e = sb.pop_front();
      checks++; if (nb !== e.lat) begin errors++; $display("FAIL mult%0d_latency: got %0d want %0d", i, nb, e.lat); end
      checks++; if (bus.HI !== e.hi) begin errors++; $display("FAIL mult%0d_hi: got %h want %h", i, bus.HI, e.hi); end
      checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL mult%0d_lo: got %h want %h", i, bus.LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_div();
    row_t rows[4] = '{
      '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14},
      '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000},
      '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD}
    };
    exp_t e;
    int   nb;
    foreach (rows[i]) begin
      e.hi = rows[i].hi; e.lo = rows[i].lo; e.lat = DC;
      run_op(rows[i].op, rows[i].a, rows[i].b, e, 0, nb);
      e = sb.pop_front();
      checks++; if (nb !== e.lat) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, nb, e.lat); end
      checks++; if (bus.HI !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, bus.HI, e.hi); end
      checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, bus.LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_mt_mf();
    exp_t e;
    int   nb;
    bus.MDOp = OP_MTHI; bus.A = 32'h1234_5678; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.MDOp = OP_MFHI;
    m_hi = 32'h1234_5678;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    checks++; if (bus.HI !== m_hi) begin errors++; $display("FAIL mthi_hi: got %h want %h", bus.HI, m_hi); end
    checks++; if (bus.MDOut !== m_hi) begin errors++; $display("FAIL mfhi_out: got %h want %h", bus.MDOut, m_hi); end
    @(negedge clk);
    bus.MDOp = OP_MTLO; bus.A = 32'hCAFE_F00D; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.MDOp = OP_MFLO;
    m_lo = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.LO !== m_lo) begin errors++; $display("FAIL mtlo_lo: got %h want %h", bus.LO, m_lo); end
    checks++; if (bus.MDOut !== m_lo) begin errors++; $display("FAIL mflo_out: got %h want %h", bus.MDOut, m_lo); end
    bus.MDOp = OP_NONE;
    #1;
    checks++; if (bus.MDOut !== 32'd0) begin errors++; $display("FAIL none_out: got %h want 0", bus.MDOut); end
    @(negedge clk);
    e = model(OP_DIVU, 32'd5, 32'd0);
    run_op(OP_DIVU, 32'd5, 32'd0, e, 0, nb);
    e = sb.pop_front();
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL div0_latency: got %0d want %0d", nb, e.lat); end
    checks++; if (bus.HI !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi: got %h want 12345678", bus.HI); end
    checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL div0_lo: got %h want %h", bus.LO, e.lo); end
  endtask

  task automatic test_cancel();
    exp_t e;
    int   nb;
    bus.MDOp = OP_MULT; bus.A = 32'd7; bus.B = 32'd9; bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0; bus.MDOp = OP_NONE;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    repeat (MC + 1) @(negedge clk);
    checks++; if (bus.HI !== m_hi) begin errors++; $display("FAIL cancel_hi: got %h want %h", bus.HI, m_hi); end
    checks++; if (bus.LO !== m_lo) begin errors++; $display("FAIL cancel_lo: got %h want %h", bus.LO, m_lo); end
    e = model(OP_MULT, 32'hFFFF_FF00, 32'd1000);
    run_op(OP_MULT, 32'hFFFF_FF00, 32'd1000, e, 1, nb);
    e = sb.pop_front();
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL inflight_cancel_latency: got %0d want %0d", nb, e.lat); end
    checks++; if (bus.HI !== e.hi) begin errors++; $display("FAIL inflight_cancel_hi: got %h want %h", bus.HI, e.hi); end
    checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL inflight_cancel_lo: got %h want %h", bus.LO, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          nb;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      e  = model(op, a, b);
      run_op(op, a, b, e, 0, nb);
      e = sb.pop_front();
      checks++; if (nb !== e.lat) begin errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, nb, e.lat); end
      checks++; if (bus.HI !== e.hi) begin errors++; $display("FAIL b2b%0d_hi: op %0d a %h b %h got %h want %h", i, op, a, b, bus.HI, e.hi); end
      checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL b2b%0d_lo: op %0d a %h b %h got %h want %h", i, op, a, b, bus.LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_stall_violation();
    exp_t e;
    int   nb;
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL no_stall_violation: got %0d want 0", viol_cnt); end
    e = model(OP_MULT, 32'h0000_1234, 32'h0000_0010);
    run_op(OP_MULT, 32'h0000_1234, 32'h0000_0010, e, 2, nb);
    e = sb.pop_front();
    checks++; if (nb !== e.lat) begin errors++; $display("FAIL stall_latency: got %0d want %0d", nb, e.lat); end
    checks++; if (bus.HI !== e.hi) begin errors++; $display("FAIL stall_hi: got %h want %h", bus.HI, e.hi); end
    checks++; if (bus.LO !== e.lo) begin errors++; $display("FAIL stall_lo: got %h want %h", bus.LO, e.lo); end
    checks++; if (viol_cnt !== 1) begin errors++; $display("FAIL stall_flagged: got %0d want 1", viol_cnt); end
    m_hi = e.hi; m_lo = e.lo;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_idle_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    bus.MDOp = OP_DIV; bus.A = 32'd100; bus.B = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.MDOp = OP_NONE;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before: got %b want 1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL midrun_reset_hi: got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL midrun_reset_lo: got %h want 0", bus.LO); end
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) @(negedge clk);
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL midrun_late_hi: got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL midrun_late_lo: got %h want 0", bus.LO); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_late_busy: got %b want 0", bus.busy); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_cancel();
    test_back_to_back();
    test_stall_violation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the pipelined MIPS core. It sits beside the arithmetic unit and receives the same forwarded A/B operands. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, holds the architectural HI/LO registers, and services MTHI/MTLO/MFHI/MFLO. The hazard unit in ID stalls any MD-class instruction while `start` or `busy` is high. The exception logic uses `cancel` to suppress a `start` that must not commit.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `A`  input  32  operand 1 (rs, forwarded).
- `B`  input  32  operand 2 (rt, forwarded).
- `MDOp`  input  4  operation code, encoded per `mdu_pkg`.
- `start`  input  1  the MD instruction in EX is valid this cycle.
- `cancel`  input  1  flush; blocks a same-cycle `start`.
- `busy`  output  1  a multi-cycle operation is in flight.
- `HI`  output  32  architectural HI.
- `LO`  output  32  architectural LO.
- `MDOut`  output  32  MFHI → HI, MFLO → LO, else 0; combinational.

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter active.
- Accepted start: `start`=1, `cancel`=0, state IDLE.
- MULT/MULTU accepted:
  - 64-bit product of A×B is latched into shadow registers hi_t/lo_t (signed or unsigned).
  - Counter is loaded with MULT_CYCLES; state goes to RUN.
- DIV/DIVU accepted:
  - lo_t = quotient, hi_t = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Counter is loaded with DIV_CYCLES.
- Divide by zero: the full latency still runs; HI/LO are left unchanged at completion.
- RUN: counter decrements each cycle. When it reaches 1: HI←hi_t, LO←lo_t, state → IDLE.
- MTHI/MTLO accepted: HI←A or LO←A at that edge. No RUN state.
- MFHI/MFLO and NONE: no state change.
- `start` while RUN: ignored, and HI/LO are not disturbed. This is a stall violation upstream; the bench asserts it never happens.
- `cancel`:
  - Affects only a same-cycle `start`.
  - An operation already in RUN completes, because it was committed before the exception.
- Operands are sampled only at the accepted-start edge. A/B changes during RUN have no effect.
- Reset, at any time including mid-RUN: HI=0, LO=0, busy=0, counter=0, state IDLE, shadow registers cleared. The in-flight result is discarded.

## Timing
- Start accepted at edge E0:
  - `busy`=1 from E0 through edge E_N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at E_N.
  - `busy`=0 and new HI/LO are visible in the cycle after E_N.
- MTHI/MTLO: new value is visible the cycle after the edge; `busy` stays 0.
- `MDOut` has zero latency from HI/LO and MDOp. It shows stale values while busy; the ID stall covers this.
- Back-to-back: a new start is accepted in the first cycle `busy`=0.

## Structure
- `mdu_pkg` holds the MDOp encodings:
  - NONE=0000, MULT=0001, MULTU=0010, DIV=0011, DIVU=0100.
  - MTHI=0101, MTLO=0110, MFHI=0111, MFLO=1000.
  - The decoder and hazard unit share this package.
- One sub-module, `mdu_calc`: combinational 64-bit product, quotient and remainder with signed/unsigned select.
- `mdu` owns the counter, state, shadow registers and HI/LO.

## Test plan
- MULT A=0xFFFFFFFE, B=3: busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 gives LO=14, HI=2.
- MTHI A=0x12345678, then MFHI: next cycle HI=0x12345678 and MDOut=0x12345678. DIVU with B=0 afterwards: 10 busy cycles, HI still 0x12345678.
- MULT with `start`=1 and `cancel`=1: busy stays 0 and HI/LO are unchanged. Cancel asserted during an in-flight MULT: the result still lands at cycle 5.
- Reset pulsed low at cycle 3 of a DIV: busy, HI and LO go to 0 immediately and asynchronously, and no update occurs at cycle 10.
- Operands changed during RUN, plus a start pulse injected while busy: result reflects only the originally sampled operands, and the stall-violation assertion flags the illegal start.
